axi_portal_sequencer: RTL and testbench

Sequences AXI slave-side read/write bursts onto a single shared register-access port. It sits between the MaxiO/MaxiI channel fields and a portal register space. It arbitrates round-robin between pending AR and AW requests, runs one burst at a time with a beat counter and per-beat address generation, and returns R beats and B responses. It replaces ad-hoc per-rule read/write counters with one explicit state machine.

---
 rtl/axi_seq_pkg.sv | 31 +++
 rtl/axi_portal_sequencer_if.sv | 61 ++++++
 rtl/axi_seq_rr_arbiter.sv | 30 +++
 rtl/axi_portal_sequencer.sv | 158 +++++++++++++++
 tb/tb_axi_portal_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_seq_pkg.sv
// Shared types for the AXI portal sequencer:
// FSM states, response codes and the burst context.
package axi_seq_pkg;

  localparam int SEQ_ID_W = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    WR      = 2'd2,
    WR_RESP = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [29:0]         addr;
    logic [SEQ_ID_W-1:0] id;
    logic [3:0]          len;
    logic [3:0]          beat;
  } burst_ctx_t;

  function automatic logic addr_in_range(
    input logic [29:0] a,
    input int          aw
  );
    return (a >> aw) == 30'd0;
  endfunction

endpackage

// File: rtl/axi_portal_sequencer_if.sv
// AXI slave-side channel bundle for the portal sequencer.
// master = bus driver, slave = sequencer.
interface axi_portal_sequencer_if #(
  parameter int ID_WIDTH = 12
);
  logic                AR__ENA;
  logic                AR__RDY;
  logic [31:0]         AR_addr;
  logic [ID_WIDTH-1:0] AR_id;
  logic [3:0]          AR_len;

  logic                AW__ENA;
  logic                AW__RDY;
  logic [31:0]         AW_addr;
  logic [ID_WIDTH-1:0] AW_id;
  logic [3:0]          AW_len;

  logic                W__ENA;
  logic                W__RDY;
  logic [31:0]         W_data;
  logic [ID_WIDTH-1:0] W_id;
  logic                W_last;

  logic                R__ENA;
  logic                R__RDY;
  logic [31:0]         R_data;
  logic [ID_WIDTH-1:0] R_id;
  logic                R_last;
  logic [1:0]          R_resp;

  logic                B__ENA;
  logic                B__RDY;
  logic [ID_WIDTH-1:0] B_id;
  logic [1:0]          B_resp;

  modport master (
    output AR__ENA, AR_addr, AR_id, AR_len,
    input  AR__RDY,
    output AW__ENA, AW_addr, AW_id, AW_len,
    input  AW__RDY,
    output W__ENA, W_data, W_id, W_last,
    input  W__RDY,
    input  R__ENA, R_data, R_id, R_last, R_resp,
    output R__RDY,
    input  B__ENA, B_id, B_resp,
    output B__RDY
  );

  modport slave (
    input  AR__ENA, AR_addr, AR_id, AR_len,
    output AR__RDY,
    input  AW__ENA, AW_addr, AW_id, AW_len,
    output AW__RDY,
    input  W__ENA, W_data, W_id, W_last,
    output W__RDY,
    output R__ENA, R_data, R_id, R_last, R_resp,
    input  R__RDY,
    output B__ENA, B_id, B_resp,
    input  B__RDY
  );
endinterface

// File: rtl/axi_seq_rr_arbiter.sv
// Two-requester round-robin arbiter; req[0]=read, req[1]=write.
// last_gnt holds 1 when write was granted last.
module axi_seq_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       fire,
  output logic [1:0] gnt,
  output logic       last_gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Reset to write so the first tie goes to the read side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_gnt <= 1'b1;
    else if (fire)
      last_gnt <= gnt[1];
  end

endmodule

// File: rtl/axi_portal_sequencer.sv
// Sequences AXI read/write bursts onto one register port.
// Optional AXI_SEQ_TRACE_EN adds trace_enable/trace_data.
module axi_portal_sequencer
  import axi_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int ID_WIDTH   = 12
) (
  input  logic                  CLK,
  input  logic                  nRST,
  axi_portal_sequencer_if.slave bus,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [31:0]           reg_rdata,
  output logic                  reg_we,
  output logic [31:0]           reg_wdata
`ifdef AXI_SEQ_TRACE_EN
  ,
  output logic                  trace_enable,
  output logic [3:0]            trace_data
`endif
);

  state_e     state, state_n;
  burst_ctx_t ctx;
  logic       err;
  logic       open;
  logic [1:0] req, gnt;
  logic       last_gnt;
  logic       ar_fire, aw_fire;
  logic       w_fire, r_fire, b_fire;
  logic [29:0] baddr;
  logic       in_rng, is_last;
  logic       unused_ok;

  assign unused_ok = ^{bus.W_id, bus.AR_addr[1:0],
                       bus.AW_addr[1:0], last_gnt};

  assign baddr   = ctx.addr + 30'(ctx.beat);
  assign in_rng  = addr_in_range(baddr, ADDR_WIDTH);
  assign is_last = ctx.beat == ctx.len;

  assign reg_addr  = baddr[ADDR_WIDTH-1:0];
  assign reg_wdata = bus.W_data;

  assign req     = {bus.AW__ENA, bus.AR__ENA};
  assign ar_fire = bus.AR__ENA & bus.AR__RDY;
  assign aw_fire = bus.AW__ENA & bus.AW__RDY;
  assign w_fire  = bus.W__ENA & bus.W__RDY;
  assign r_fire  = bus.R__ENA & bus.R__RDY;
  assign b_fire  = bus.B__ENA & bus.B__RDY;

  axi_seq_rr_arbiter u_arb (
    .clk      (CLK),
    .rst_n    (nRST),
    .req      (req),
    .fire     (ar_fire | aw_fire),
    .gnt      (gnt),
    .last_gnt (last_gnt)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (ar_fire)      state_n = RD;
        else if (aw_fire) state_n = WR;
      RD:
        if (r_fire && is_last) state_n = IDLE;
      WR:
        if (w_fire && (bus.W_last || is_last))
          state_n = WR_RESP;
      WR_RESP:
        if (b_fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.AR__RDY = 1'b0;
    bus.AW__RDY = 1'b0;
    bus.W__RDY  = 1'b0;
    bus.R__ENA  = 1'b0;
    bus.R_data  = 32'd0;
    bus.R_id    = '0;
    bus.R_last  = 1'b0;
    bus.R_resp  = RESP_OKAY;
    bus.B__ENA  = 1'b0;
    bus.B_id    = '0;
    bus.B_resp  = RESP_OKAY;
    reg_we      = 1'b0;
    unique case (state)
      IDLE: begin
        // On a tie only the granted side sees RDY.
        bus.AR__RDY = open & ~(&req & ~gnt[0]);
        bus.AW__RDY = open & ~(&req & ~gnt[1]);
      end
      RD: begin
        bus.R__ENA = 1'b1;
        bus.R_data = in_rng ? reg_rdata : 32'd0;
        bus.R_id   = ID_WIDTH'(ctx.id);
        bus.R_last = is_last;
        bus.R_resp = in_rng ? RESP_OKAY : RESP_SLVERR;
      end
      WR: begin
        bus.W__RDY = 1'b1;
        reg_we     = bus.W__ENA & in_rng;
      end
      WR_RESP: begin
        bus.B__ENA = 1'b1;
        bus.B_id   = ID_WIDTH'(ctx.id);
        bus.B_resp = err ? RESP_SLVERR : RESP_OKAY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ctx  <= '0;
      err  <= 1'b0;
      open <= 1'b0;
    end else begin
      open <= 1'b1;
      if (ar_fire) begin
        ctx <= '{addr: bus.AR_addr[31:2],
                 id:   SEQ_ID_W'(bus.AR_id),
                 len:  bus.AR_len,
                 beat: 4'd0};
        err <= 1'b0;
      end else if (aw_fire) begin
        ctx <= '{addr: bus.AW_addr[31:2],
                 id:   SEQ_ID_W'(bus.AW_id),
                 len:  bus.AW_len,
                 beat: 4'd0};
        err <= 1'b0;
      end else if (r_fire) begin
        ctx.beat <= ctx.beat + 4'd1;
      end else if (w_fire) begin
        ctx.beat <= ctx.beat + 4'd1;
        // Early W_last and missing W_last both flag an error.
        err <= err | ~in_rng | (bus.W_last ^ is_last);
      end
    end
  end

`ifdef AXI_SEQ_TRACE_EN
  assign trace_enable = state_n != state;
  assign trace_data   = {state, last_gnt, err};
`endif

endmodule

// File: tb/tb_axi_portal_sequencer.sv
// Scoreboard bench for axi_portal_sequencer.
// Expectations are queued at issue; a monitor pops them.
module tb_axi_portal_sequencer;
  import axi_seq_pkg::*;

  localparam int AW = 10;
  localparam int IW = 12;

  typedef struct packed {
    logic [31:0]   data;
    logic [IW-1:0] id;
    logic          last;
    logic [1:0]    resp;
  } rexp_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } bexp_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wexp_t;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic [AW-1:0] reg_addr;
  logic [31:0]   reg_rdata;
  logic          reg_we;
  logic [31:0]   reg_wdata;
  int            checks = 0;
  int            errors = 0;
  time           t_ar, t_aw;

  rexp_t rq[$];
  bexp_t bq[$];
  wexp_t wq[$];

  always #5 clk = ~clk;

  axi_portal_sequencer_if #(.ID_WIDTH(IW)) bus();

`ifdef AXI_SEQ_TRACE_EN
  logic       trace_enable;
  logic [3:0] trace_data;
`endif

  axi_portal_sequencer #(
    .ADDR_WIDTH (AW),
    .ID_WIDTH   (IW)
  ) dut (
    .CLK       (clk),
    .nRST      (nrst),
    .bus       (bus),
    .reg_addr  (reg_addr),
    .reg_rdata (reg_rdata),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata)
`ifdef AXI_SEQ_TRACE_EN
    ,
    .trace_enable (trace_enable),
    .trace_data   (trace_data)
`endif
  );

  assign reg_rdata = 32'h100 + 32'(reg_addr);

  function automatic void chk(string name,
                              logic [63:0] got,
                              logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endfunction

  function automatic void push_r(logic [31:0] d,
                                 logic [IW-1:0] id,
                                 logic l, logic [1:0] r);
    rexp_t e;
    e.data = d; e.id = id; e.last = l; e.resp = r;
    rq.push_back(e);
  endfunction

  function automatic void push_b(logic [IW-1:0] id,
                                 logic [1:0] r);
    bexp_t e;
    e.id = id; e.resp = r;
    bq.push_back(e);
  endfunction

  function automatic void push_w(logic [AW-1:0] a,
                                 logic [31:0] d);
    wexp_t e;
    e.addr = a; e.data = d;
    wq.push_back(e);
  endfunction

  // Monitor: samples 1ns before each rising edge.
  initial begin
    rexp_t re;
    bexp_t be;
    wexp_t we;
    forever begin
      @(negedge clk);
      #4;
      if (nrst) begin
        if (bus.R__ENA && bus.R__RDY) begin
          if (rq.size() == 0) begin
            chk("r_unexpected", 1, 0);
          end else begin
            re = rq.pop_front();
            chk("r_beat",
                {bus.R_data, bus.R_id, bus.R_last, bus.R_resp},
                re);
          end
        end
        if (bus.B__ENA && bus.B__RDY) begin
          if (bq.size() == 0) begin
            chk("b_unexpected", 1, 0);
          end else begin
            be = bq.pop_front();
            chk("b_resp", {bus.B_id, bus.B_resp}, be);
          end
        end
        if (reg_we) begin
          if (wq.size() == 0) begin
            chk("we_unexpected", 1, 0);
          end else begin
            we = wq.pop_front();
            chk("reg_write", {reg_addr, reg_wdata}, we);
          end
        end
      end
    end
  end

  task automatic ar_req(input logic [31:0] a,
                        input logic [IW-1:0] id,
                        input logic [3:0] len,
                        output time t);
    int n;
    n = 0;
    t = 0;
    @(negedge clk);
    bus.AR__ENA = 1'b1;
    bus.AR_addr = a;
    bus.AR_id   = id;
    bus.AR_len  = len;
    #1;
    while (!bus.AR__RDY && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      chk("ar_timeout", 1, 0);
      bus.AR__ENA = 1'b0;
    end else begin
      @(posedge clk);
      t = $time;
      #1;
      bus.AR__ENA = 1'b0;
      chk("r_latency", bus.R__ENA, 1);
    end
  endtask

  task automatic aw_req(input logic [31:0] a,
                        input logic [IW-1:0] id,
                        input logic [3:0] len,
                        output time t);
    int n;
    n = 0;
    t = 0;
    @(negedge clk);
    bus.AW__ENA = 1'b1;
    bus.AW_addr = a;
    bus.AW_id   = id;
    bus.AW_len  = len;
    #1;
    while (!bus.AW__RDY && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      chk("aw_timeout", 1, 0);
      bus.AW__ENA = 1'b0;
    end else begin
      @(posedge clk);
      t = $time;
      #1;
      bus.AW__ENA = 1'b0;
      chk("w_rdy_latency", bus.W__RDY, 1);
    end
  endtask

  task automatic w_beats(input int n,
                         input logic [31:0] base,
                         input int last_at);
    int k;
    for (int i = 0; i < n; i++) begin
      k = 0;
      @(negedge clk);
      bus.W__ENA = 1'b1;
      bus.W_data = base + 32'(i);
      bus.W_last = (i == last_at);
      #1;
      while (!bus.W__RDY && k < 50) begin
        @(negedge clk); #1; k++;
      end
      if (k >= 50) chk("w_timeout", 1, 0);
      @(posedge clk);
      #1;
      bus.W__ENA = 1'b0;
      bus.W_last = 1'b0;
    end
    chk("b_latency", bus.B__ENA, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rq.size() + bq.size() + wq.size()) != 0
           && n < 60) begin
      @(posedge clk); n++;
    end
    chk("drain_timeout", n >= 60, 0);
    @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    bus.AR__ENA = 0; bus.AR_addr = 0;
    bus.AR_id = 0;   bus.AR_len = 0;
    bus.AW__ENA = 0; bus.AW_addr = 0;
    bus.AW_id = 0;   bus.AW_len = 0;
    bus.W__ENA = 0;  bus.W_data = 0;
    bus.W_id = 0;    bus.W_last = 0;
    bus.R__RDY = 1;  bus.B__RDY = 1;

    // Reset values
    #3;
    chk("rst_ar_rdy", bus.AR__RDY, 0);
    chk("rst_aw_rdy", bus.AW__RDY, 0);
    chk("rst_r_ena", bus.R__ENA, 0);
    chk("rst_b_ena", bus.B__ENA, 0);
    chk("rst_w_rdy", bus.W__RDY, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_r_fields",
        {bus.R_data, bus.R_id, bus.R_last, bus.R_resp}, 0);
    chk("rst_b_fields", {bus.B_id, bus.B_resp}, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("rdy_before_edge", bus.AR__RDY, 0);
    @(posedge clk);
    #1;
    chk("ar_rdy_after_rst", bus.AR__RDY, 1);
    chk("aw_rdy_after_rst", bus.AW__RDY, 1);

    // Tie straight after reset: read first
    push_r(32'h108, 12'd1, 1'b1, RESP_OKAY);
    push_w(10'd2, 32'hC);
    push_b(12'd2, RESP_OKAY);
    fork
      ar_req(32'h20, 12'd1, 4'd0, t_ar);
      begin
        aw_req(32'h8, 12'd2, 4'd0, t_aw);
        w_beats(1, 32'hC, 0);
      end
    join
    chk("tie1_read_first", t_ar < t_aw, 1);

    // Second tie: last grant was write, read wins
    push_r(32'h109, 12'd3, 1'b1, RESP_OKAY);
    push_w(10'd3, 32'hD);
    push_b(12'd4, RESP_OKAY);
    fork
      ar_req(32'h24, 12'd3, 4'd0, t_ar);
      begin
        aw_req(32'hC, 12'd4, 4'd0, t_aw);
        w_beats(1, 32'hD, 0);
      end
    join
    chk("tie2_read_first", t_ar < t_aw, 1);
    drain();

    // 4-beat read at 0x10
    push_r(32'h104, 12'd5, 1'b0, RESP_OKAY);
    push_r(32'h105, 12'd5, 1'b0, RESP_OKAY);
    push_r(32'h106, 12'd5, 1'b0, RESP_OKAY);
    push_r(32'h107, 12'd5, 1'b1, RESP_OKAY);
    ar_req(32'h10, 12'd5, 4'd3, t_ar);
    drain();

    // 2-beat write at 0x0
    push_w(10'd0, 32'hA);
    push_w(10'd1, 32'hB);
    push_b(12'd7, RESP_OKAY);
    aw_req(32'h0, 12'd7, 4'd1, t_aw);
    w_beats(2, 32'hA, 1);
    drain();

    // Early W_last on beat 2 of 4
    push_w(10'h10, 32'h50);
    push_w(10'h11, 32'h51);
    push_b(12'd8, RESP_SLVERR);
    aw_req(32'h40, 12'd8, 4'd3, t_aw);
    w_beats(2, 32'h50, 1);
    push_r(32'h101, 12'd9, 1'b1, RESP_OKAY);
    ar_req(32'h4, 12'd9, 4'd0, t_ar);
    drain();

    // Out of range read and write
    push_r(32'h0, 12'd10, 1'b1, RESP_SLVERR);
    ar_req(32'h1000, 12'd10, 4'd0, t_ar);
    push_b(12'd11, RESP_SLVERR);
    aw_req(32'h1000, 12'd11, 4'd0, t_aw);
    w_beats(1, 32'h77, 0);
    drain();

    // Reset during beat 2 of a read
    push_r(32'h120, 12'd12, 1'b0, RESP_OKAY);
    push_r(32'h121, 12'd12, 1'b0, RESP_OKAY);
    push_r(32'h122, 12'd12, 1'b0, RESP_OKAY);
    push_r(32'h123, 12'd12, 1'b1, RESP_OKAY);
    ar_req(32'h80, 12'd12, 4'd3, t_ar);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("r_ena_before_rst", bus.R__ENA, 1);
    nrst = 1'b0;
    #1;
    rq.delete();
    chk("rst_mid_r_ena", bus.R__ENA, 0);
    chk("rst_mid_ar_rdy", bus.AR__RDY, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_rdy_after_rst2", bus.AR__RDY, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_stale_r", bus.R__ENA, 0);
    end
    push_r(32'h102, 12'd13, 1'b1, RESP_OKAY);
    ar_req(32'h8, 12'd13, 4'd0, t_ar);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
